// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA receive monitor: FSM encodings, geometry record, CRC-16 step.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_PEND   = 2'd1,
    CAP_ACTIVE = 2'd2,
    CAP_DONE   = 2'd3
  } cap_state_e;

  // Geometry fields are held at a fixed width so frames can be compared as one record.
  localparam int GEO_W = 16;

  typedef struct packed {
    logic [GEO_W-1:0] h_total;
    logic [GEO_W-1:0] h_active;
    logic [GEO_W-1:0] v_total;
    logic [GEO_W-1:0] v_active;
  } geom_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // CRC-16-CCITT advanced over one 24-bit pixel, MSB first.
  function automatic logic [15:0] crc16_step24(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_edge.sv
// Registers one sync input, normalises its polarity and flags the leading edge of the asserted level.
module vga_rx_edge #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_level,
  output logic o_lead
);

  logic r_level;
  logic r_prev;
  logic r_level_vld;
  logic r_prev_vld;

  // NOTE: all sequential state uses non-blocking assignments so each register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= 1'b0;
      r_prev      <= 1'b0;
      r_level_vld <= 1'b0;
      r_prev_vld  <= 1'b0;
    end else begin
      r_level     <= (ACTIVE_LOW != 0) ? ~i_sync : i_sync;
      r_prev      <= r_level;
      r_level_vld <= 1'b1;
      r_prev_vld  <= r_level_vld;
    end
  end

  assign o_level = r_level;
  // A sync already asserted when reset releases is not an edge: wait for a real previous sample.
  assign o_lead  = r_level & ~r_prev & r_prev_vld;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: frame geometry measurement, lock tracking and single-pixel capture.
// Defining VGA_RX_CRC_EN adds frame_crc, a CRC-16-CCITT over each frame's active pixels.
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int HW              = 11,
  parameter int VW              = 10,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hblank,
  input  logic          vblank,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  input  logic [HW-1:0] cap_x,
  input  logic [VW-1:0] cap_y,
  input  logic          cap_req,
  output logic          cap_done,
  output logic [23:0]   cap_rgb,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          locked,
`ifdef VGA_RX_CRC_EN
  output logic [15:0]   frame_crc,
`endif
  output logic [7:0]    frame_cnt
);

  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  logic w_hs_level, w_hs_lead, w_vs_level, w_vs_lead;

  vga_rx_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
    .clk(clk), .rst(rst), .i_sync(hsync), .o_level(w_hs_level), .o_lead(w_hs_lead)
  );

  vga_rx_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
    .clk(clk), .rst(rst), .i_sync(vsync), .o_level(w_vs_level), .o_lead(w_vs_lead)
  );

  logic        r_hblank, r_vblank;
  logic [23:0] r_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_rgb    <= '0;
    end else begin
      r_hblank <= hblank;
      r_vblank <= vblank;
      r_rgb    <= {r, g, b};
    end
  end

  logic w_pix_act;
  assign w_pix_act = ~r_hblank & ~r_vblank;

  logic [HW-1:0] r_hcnt, r_line_len, r_xcnt, r_hact_max;
  logic [VW-1:0] r_lines, r_alines;
  logic          r_sat;

  logic [HW-1:0] w_line_len_nx, w_hact_nx;
  logic [VW-1:0] w_lines_nx, w_alines_nx;
  logic          w_sat_nx;

  // Next-state views fold a same-clock hsync edge into the frame before it is latched.
  assign w_line_len_nx = w_hs_lead ? r_hcnt : r_line_len;
  assign w_hact_nx     = (r_xcnt > r_hact_max) ? r_xcnt : r_hact_max;
  assign w_lines_nx    = (w_hs_lead && r_lines != V_MAX) ? r_lines + 1'b1 : r_lines;
  assign w_alines_nx   = (w_hs_lead && !r_vblank && r_alines != V_MAX) ? r_alines + 1'b1 : r_alines;
  assign w_sat_nx      = r_sat | (r_hcnt == H_MAX) | (r_xcnt == H_MAX)
                       | (r_lines == V_MAX) | (r_alines == V_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt     <= '0;
      r_line_len <= '0;
      r_xcnt     <= '0;
      r_hact_max <= '0;
      r_lines    <= '0;
      r_alines   <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_hs_lead) begin
        r_hcnt     <= HW'(1);
        r_line_len <= r_hcnt;
        r_xcnt     <= '0;
      end else begin
        if (r_hcnt != H_MAX) r_hcnt <= r_hcnt + 1'b1;
        if (w_pix_act && r_xcnt != H_MAX) r_xcnt <= r_xcnt + 1'b1;
      end
      if (w_vs_lead) begin
        r_lines    <= '0;
        r_alines   <= '0;
        r_hact_max <= '0;
        r_sat      <= 1'b0;
      end else begin
        r_lines    <= w_lines_nx;
        r_alines   <= w_alines_nx;
        r_hact_max <= w_hact_nx;
        r_sat      <= w_sat_nx;
      end
    end
  end

  geom_t w_geom_new;
  geom_t r_geom_prev;
  logic  w_match;

  assign w_geom_new = '{h_total:  GEO_W'(w_line_len_nx),
                        h_active: GEO_W'(w_hact_nx),
                        v_total:  GEO_W'(w_lines_nx),
                        v_active: GEO_W'(w_alines_nx)};
  assign w_match    = (w_geom_new == r_geom_prev) && !w_sat_nx;

  rx_state_e     r_state;
  logic [2:0]    r_stable;
  logic          r_locked;
  logic [HW-1:0] r_h_total, r_h_active;
  logic [VW-1:0] r_v_total, r_v_active;
  logic [7:0]    r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_stable    <= '0;
      r_locked    <= 1'b0;
      r_geom_prev <= '0;
      r_h_total   <= '0;
      r_h_active  <= '0;
      r_v_total   <= '0;
      r_v_active  <= '0;
      r_frame_cnt <= '0;
    end else if (w_vs_lead) begin
      r_h_total   <= w_line_len_nx;
      r_h_active  <= w_hact_nx;
      r_v_total   <= w_lines_nx;
      r_v_active  <= w_alines_nx;
      r_frame_cnt <= r_frame_cnt + 8'd1;
      r_geom_prev <= w_geom_new;
      case (r_state)
        ST_SEARCH: begin
          r_state  <= ST_MEASURE;
          r_stable <= '0;
        end
        ST_MEASURE: begin
          if (w_match) begin
            r_stable <= r_stable + 3'd1;
            if (r_stable + 3'd1 >= 3'(LOCK_FRAMES)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end else begin
            r_stable <= '0;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            r_state  <= ST_MEASURE;
            r_locked <= 1'b0;
            r_stable <= '0;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  cap_state_e    r_cap_st;
  logic [HW-1:0] r_cap_x;
  logic [VW-1:0] r_cap_y;
  logic [23:0]   r_cap_rgb;
  logic          r_cap_done;
  logic          w_cap_hit;

  // A pixel inside a sync pulse is never a valid capture target.
  assign w_cap_hit = (r_cap_st == CAP_ACTIVE) && w_pix_act && !w_hs_level && !w_vs_level
                   && (r_xcnt == r_cap_x) && (r_alines == r_cap_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_st   <= CAP_IDLE;
      r_cap_x    <= '0;
      r_cap_y    <= '0;
      r_cap_rgb  <= '0;
      r_cap_done <= 1'b0;
    end else begin
      r_cap_done <= 1'b0;
      case (r_cap_st)
        CAP_IDLE: begin
          if (cap_req && r_locked) begin
            r_cap_st <= CAP_PEND;
            r_cap_x  <= cap_x;
            r_cap_y  <= cap_y;
          end
        end
        CAP_PEND: begin
          if (!cap_req || !r_locked) r_cap_st <= CAP_IDLE;
          else if (w_vs_lead)        r_cap_st <= CAP_ACTIVE;
        end
        CAP_ACTIVE: begin
          if (!cap_req || !r_locked) begin
            r_cap_st <= CAP_IDLE;
          end else if (w_cap_hit) begin
            r_cap_rgb  <= r_rgb;
            r_cap_done <= 1'b1;
            r_cap_st   <= CAP_DONE;
          end else if (w_vs_lead) begin
            r_cap_st <= CAP_IDLE;
          end
        end
        CAP_DONE: begin
          if (!cap_req) r_cap_st <= CAP_IDLE;
        end
        default: r_cap_st <= CAP_IDLE;
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc, r_frame_crc, w_crc_nx;

  assign w_crc_nx = w_pix_act ? crc16_step24(r_crc, r_rgb) : r_crc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc       <= CRC_INIT;
      r_frame_crc <= '0;
    end else if (w_vs_lead) begin
      r_frame_crc <= w_crc_nx;
      r_crc       <= CRC_INIT;
    end else begin
      r_crc <= w_crc_nx;
    end
  end

  assign frame_crc = r_frame_crc;
`endif

  assign cap_done  = r_cap_done;
  assign cap_rgb   = r_cap_rgb;
  assign h_total   = r_h_total;
  assign h_active  = r_h_active;
  assign v_total   = r_v_total;
  assign v_active  = r_v_active;
  assign locked    = r_locked;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor: a reduced-timing model controller drives the monitor.
// Define VGA_RX_CRC_EN for both bench and RTL to exercise frame_crc.
module tb_vga_rx_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, hblank = 1'b1, vblank = 1'b1;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic [10:0] cap_x = '0;
  logic [9:0]  cap_y = '0;
  logic        cap_req = 1'b0;
  logic        cap_done;
  logic [23:0] cap_rgb;
  logic [10:0] h_total, h_active;
  logic [9:0]  v_total, v_active;
  logic        locked;
  logic [7:0]  frame_cnt;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frame_crc;
`endif

  always #5 clk = ~clk;

  vga_rx_monitor dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .r(r), .g(g), .b(b), .cap_x(cap_x), .cap_y(cap_y), .cap_req(cap_req),
    .cap_done(cap_done), .cap_rgb(cap_rgb), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .locked(locked),
`ifdef VGA_RX_CRC_EN
    .frame_crc(frame_crc),
`endif
    .frame_cnt(frame_cnt)
  );

  int errors = 0;
  int checks = 0;
  int hbp = 5;
  bit zero_pix = 1'b0;
  int vs_edges = 0;
  int vs_base = 0;
  int done_pulses = 0;
  int ctl_line = 10;
  int ctl_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Model controller: 16 active, 4 front porch, 3 sync, hbp back porch; lines 0-9 active, vsync on line 10.
  initial begin
    forever begin
      ctl_total = 16 + 4 + 3 + hbp;
      for (int p = 0; p < ctl_total; p++) begin
        @(posedge clk);
        #1;
        hblank = (p >= 16);
        vblank = (ctl_line >= 10);
        hsync  = !(p >= 20 && p < 23);
        vsync  = (ctl_line != 10);
        if (p == 0 && ctl_line == 10) vs_edges++;
        if (!hblank && !vblank && !zero_pix) begin
          r = 8'(p);
          g = 8'(ctl_line);
          b = 8'hA5;
        end else begin
          r = 8'd0;
          g = 8'd0;
          b = 8'd0;
        end
      end
      ctl_line = (ctl_line == 11) ? 0 : ctl_line + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (cap_done === 1'b1) done_pulses++;
  end

  task automatic wait_frame_end(input string tag);
    int start;
    int n;
    start = vs_edges;
    n = 0;
    while (vs_edges == start && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check({tag, " frame end seen"}, 32'(vs_edges != start), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_cap(input string tag, input int limit);
    int d0;
    int n;
    d0 = done_pulses;
    n = 0;
    while (done_pulses == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, " cap_done seen"}, 32'(done_pulses - d0), 32'd1);
  endtask

  task automatic check_geom(input string tag, input int ht, input int ha, input int vt, input int va);
    check({tag, " h_total"},  32'(h_total),  32'(ht));
    check({tag, " h_active"}, 32'(h_active), 32'(ha));
    check({tag, " v_total"},  32'(v_total),  32'(vt));
    check({tag, " v_active"}, 32'(v_active), 32'(va));
  endtask

  task automatic check_fc(input string tag);
    check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(8'(vs_edges - vs_base)));
  endtask

  task automatic check_all_zero(input string tag);
    check_geom(tag, 0, 0, 0, 0);
    check({tag, " locked"},    32'(locked),    32'd0);
    check({tag, " frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, " cap_done"},  32'(cap_done),  32'd0);
    check({tag, " cap_rgb"},   32'(cap_rgb),   32'd0);
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] ref_crc_zero(input int nbits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nbits; i++)
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction
`endif

  initial begin
    int d0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    vs_base = vs_edges;
    @(negedge clk);
    check_all_zero("reset");

    // Bring-up: first full frame measured, lock after the third frame end.
    wait_frame_end("f1");
    check_geom("f1", 28, 16, 12, 10);
    check("f1 locked", 32'(locked), 32'd0);
    check_fc("f1");
    wait_frame_end("f2");
    check("f2 locked", 32'(locked), 32'd0);
    wait_frame_end("f3");
    check("f3 locked", 32'(locked), 32'd1);
    check_geom("f3", 28, 16, 12, 10);
    check_fc("f3");

    // Capture at (7,3): arming waits for the next frame end, so nothing in the current frame.
    cap_x = 11'd7;
    cap_y = 10'd3;
    cap_req = 1'b1;
    d0 = done_pulses;
    wait_frame_end("cap1 arm");
    check("cap1 early pulses", 32'(done_pulses - d0), 32'd0);
    wait_cap("cap1", 400);
    check("cap1 cap_done high", 32'(cap_done), 32'd1);
    check("cap1 cap_rgb", 32'(cap_rgb), 32'h0703A5);
    @(negedge clk);
    check("cap1 cap_done one cycle", 32'(cap_done), 32'd0);
    cap_req = 1'b0;
    repeat (4) @(negedge clk);

    // Out-of-range column: no capture, lock undisturbed; then an in-range column.
    wait_frame_end("oor sync");
    cap_x = 11'd20;
    cap_req = 1'b1;
    d0 = done_pulses;
    wait_frame_end("oor a");
    wait_frame_end("oor b");
    wait_frame_end("oor c");
    check("oor pulses", 32'(done_pulses - d0), 32'd0);
    check("oor locked", 32'(locked), 32'd1);
    cap_x = 11'd15;
    wait_cap("cap2", 1200);
    check("cap2 cap_rgb", 32'(cap_rgb), 32'h0F03A5);
    cap_req = 1'b0;

    // Back porch 5 -> 6 while locked: unlock, then relock after two stable frames.
    hbp = 6;
    wait_frame_end("hbp f1");
    check("hbp f1 locked", 32'(locked), 32'd0);
    check_geom("hbp f1", 29, 16, 12, 10);
    wait_frame_end("hbp f2");
    check("hbp f2 locked", 32'(locked), 32'd0);
    wait_frame_end("hbp f3");
    check("hbp f3 locked", 32'(locked), 32'd1);
    check("hbp f3 h_total", 32'(h_total), 32'd29);

    // One-clock reset mid-frame.
    repeat (150) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vs_base = vs_edges;
    @(negedge clk);
    check_all_zero("mid rst");
    wait_frame_end("rst f1");
    check_fc("rst f1");
    check("rst f1 locked", 32'(locked), 32'd0);
    wait_frame_end("rst f2");
    check_fc("rst f2");
    check_geom("rst f2", 29, 16, 12, 10);
    check("rst f2 locked", 32'(locked), 32'd0);
    wait_frame_end("rst f3");
    wait_frame_end("rst f4");
    check("rst f4 locked", 32'(locked), 32'd1);

`ifdef VGA_RX_CRC_EN
    zero_pix = 1'b1;
    wait_frame_end("crc f0");
    wait_frame_end("crc f1");
    check("crc f1", 32'(frame_crc), 32'(ref_crc_zero(160 * 24)));
    wait_frame_end("crc f2");
    check("crc f2", 32'(frame_crc), 32'(ref_crc_zero(160 * 24)));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA timing/colour controller: observes hsync/vsync, hblank/vblank and 8-bit r/g/b on the same pixel clock.
- Measures frame geometry, declares lock after stable frames, and captures one pixel at a programmed coordinate through a req/done handshake.
- Sits in the test/loopback path next to the controller; used on-chip for self-check and in simulation as the scoreboard front end.

Parameters:
- HW, 11, width of horizontal counters and measured horizontal values.
- VW, 10, width of vertical counters and measured vertical values.
- SYNC_ACTIVE_LOW, 1, when 1 hsync/vsync are asserted low (640x480 style); when 0, asserted high.
- LOCK_FRAMES, 2, number of consecutive identical frame measurements required to assert locked (range 1..7).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- hsync  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW.
- vsync  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW.
- hblank  in  1  1 = outside horizontal active region.
- vblank  in  1  1 = outside vertical active region.
- r, g, b  in  8 each  pixel colour, valid when hblank=0 and vblank=0.
- cap_x  in  HW  capture column (active-region coordinate).
- cap_y  in  VW  capture row (active-region coordinate).
- cap_req  in  1  capture request; level, held until cap_done.
- cap_done  out  1  one-cycle pulse, cap_rgb valid.
- cap_rgb  out  24  captured {r,g,b}; holds until the next capture.
- h_total  out  HW  clocks between hsync leading edges.
- h_active  out  HW  active clocks in the last full line.
- v_total  out  VW  lines between vsync leading edges.
- v_active  out  VW  active lines in the last full frame.
- locked  out  1  geometry stable.
- frame_cnt  out  8  frames seen, wraps 255->0.

Behaviour:
- Reset: all outputs 0, FSM = SEARCH, capture disarmed, all counters 0. Reset mid-frame discards partial measurements. Measurement then resumes at the next sync edge.
- Inputs are registered once. A leading edge is the transition into the asserted level, detected against the registered previous value. All measurements are 1 clock late versus raw inputs.
- Horizontal counter: resets to 1 on the hsync leading edge, otherwise +1, saturating at all-ones. At each leading edge, latch the count into an internal line_len.
- Active-pixel counter: increments on each clock with hblank=0 and vblank=0, saturating. x = its value before increment. Cleared at the hsync leading edge.
- Line counter: +1 per hsync leading edge. vblank=0 lines are counted separately as active lines.
- Frame end = vsync leading edge. On frame end:
  - latch h_total <= line_len;
  - latch h_active <= max active count of the frame;
  - latch v_total <= line count;
  - latch v_active <= active line count;
  - frame_cnt +1; clear the frame counters.
  - hsync and vsync leading edges on the same clock: apply the line update first, then the frame latch, so the line counts in that frame.
- FSM, evaluated on frame end only:
  - SEARCH: go to MEASURE on the first frame end. Outputs are not meaningful before this.
  - MEASURE: compare the new {h_total,v_total,h_active,v_active} with the previous one. Match: stable_cnt +1. Mismatch: stable_cnt=0. When stable_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED: any mismatch gives locked=0, stable_cnt=0, go to MEASURE. Any saturated counter counts as a mismatch.
- Capture handshake:
  - cap_req=1 while idle and locked=1 arms capture; cap_x/cap_y are sampled at arm time.
  - Arming takes effect from the next frame end, so a partial frame is never used.
  - In the following frame, the first clock with vblank=0, hblank=0, x==cap_x and active line index==cap_y: cap_rgb <= {r,g,b} (registered values) and cap_done pulses on the next clock. Then disarm.
  - If a frame ends without a match (out-of-range coordinate): cap_done does not pulse; disarm; the request re-arms while cap_req is still high.
  - If locked falls while armed: disarm with no cap_done.
  - cap_req dropped before cap_done: abort silently.
  - A new capture needs cap_req low for at least 1 clock after cap_done.

Optional Feature:
- VGA_RX_CRC_EN defined:
  - Adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {r,g,b} of every active pixel, MSB first, 24 bits per clock.
  - Latched at frame end and reset to 0.
- Undefined: the port and logic are absent.

Decomposition:
- Package vga_rx_pkg:
  - FSM state enum (SEARCH, MEASURE, LOCKED);
  - struct of measured geometry;
  - CRC_POLY and CRC_INIT constants.
- One sub-module, vga_rx_edge: registers a sync input, applies the polarity parameter, and outputs level plus a leading-edge pulse. Two instances.

Test Plan:
- Reduced timing, driven by a model controller:
  - Line: 16 active, 4 front porch, 3 sync, 5 back porch. Expect h_total=28.
  - Frame: 10 active lines, 12 total. Expect v_total=12, h_active=16, v_active=10.
  - Check after the first frame end; locked=1 after the 3rd frame end with LOCK_FRAMES=2.
- Change h back porch 5->6 while locked: expect locked=0 at the next frame end, h_total=29, then relock after 2 further stable frames.
- Gradient pattern r=x, g=y, b=0xA5 with cap_x=7, cap_y=3 and cap_req held: expect cap_done pulse in the frame after arming, cap_rgb=0x0703A5.
- cap_x=20 (beyond active): expect no cap_done across 3 frames and locked to stay 1. Then set cap_x=15: expect cap_rgb=0x0F03A5.
- Assert rst for 1 clock mid-frame 2: expect all outputs 0. Then the first valid geometry at the second subsequent vsync edge; frame_cnt restarts from 0.
- With VGA_RX_CRC_EN, all-zero pixels, 16x10 active: expect frame_crc equal to the bench's reference CRC over 160x24 zero bits, identical every frame.
